// File: rtl/ili9341_pkg.sv
// Shared ILI9341 definitions: opcodes used by the writers and the decoder,
// plus the decoder state encoding.
package ili9341_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_PASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [2:0] {
      StIdle,
      StCaset,
      StPaset,
      StRamwr,
      StSkip
   } dec_state_e;

endpackage

// File: rtl/ili9341_spi_decoder_if.sv
// Bundle for the ILI9341 serial link and the decoder's report outputs.
// master: the display writer / bench side; slave: the decoder.
interface ili9341_spi_decoder_if #(
   parameter int unsigned COORD_W = 9
);
   logic               cs;
   logic               dc;
   logic               din;
   logic               cmd_valid;
   logic [7:0]         cmd_byte;
   logic               param_valid;
   logic [7:0]         param_byte;
   logic               pix_valid;
   logic [15:0]        pix_data;
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic [COORD_W-1:0] win_xs;
   logic [COORD_W-1:0] win_xe;
   logic [COORD_W-1:0] win_ys;
   logic [COORD_W-1:0] win_ye;
   logic               frame_err;

   modport master (
      output cs, dc, din,
      input  cmd_valid, cmd_byte, param_valid, param_byte, pix_valid, pix_data,
      input  pix_x, pix_y, win_xs, win_xe, win_ys, win_ye, frame_err
   );

   modport slave (
      input  cs, dc, din,
      output cmd_valid, cmd_byte, param_valid, param_byte, pix_valid, pix_data,
      output pix_x, pix_y, win_xs, win_xe, win_ys, win_ye, frame_err
   );
endinterface

// File: rtl/ili9341_spi_byte_rx.sv
// Serial byte receiver: MSB-first shift register with a 3-bit bit counter.
// byte_valid is combinational so the decoder can act on the same edge that
// samples the eighth bit. A cs rise with a partial byte pulses frame_err.
module ili9341_spi_byte_rx (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       dc,
   input  logic       din,
   output logic       byte_valid,
   output logic       byte_dc,
   output logic [7:0] byte_data,
   output logic       frame_err
);
   logic [6:0] shift_q;
   logic [2:0] cnt_q;
   logic       frame_err_q;

   assign byte_valid = !cs && (cnt_q == 3'd7);
   assign byte_dc    = dc;
   assign byte_data  = {shift_q, din};
   assign frame_err  = frame_err_q;

   // Shift while selected; cs high aborts a partial byte and flags it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_q     <= '0;
         cnt_q       <= '0;
         frame_err_q <= 1'b0;
      end else if (cs) begin
         cnt_q       <= '0;
         frame_err_q <= (cnt_q != 3'd0);
      end else begin
         shift_q     <= {shift_q[5:0], din};
         cnt_q       <= cnt_q + 3'd1; // wraps to 0 on the eighth bit
         frame_err_q <= 1'b0;
      end
   end
endmodule

// File: rtl/ili9341_spi_decoder.sv
// ILI9341 receive-side decoder: interprets CASET/PASET/RAMWR and emits
// addressed RGB565 pixel strobes with zero added latency.
// Optional: define ILI9341_DEC_PARAM_OUT_EN to report parameter bytes of
// CASET, PASET and unrecognised commands on param_valid/param_byte.
module ili9341_spi_decoder
   import ili9341_pkg::*;
#(
   parameter int unsigned COORD_W = 9,
   parameter int unsigned X_MAX   = 239,
   parameter int unsigned Y_MAX   = 319
) (
   input logic                  clk,
   input logic                  rst,
   ili9341_spi_decoder_if.slave bus
);
   typedef logic [COORD_W-1:0] coord_t;

   logic       byte_valid;
   logic       byte_dc;
   logic [7:0] byte_data;

   ili9341_spi_byte_rx u_byte_rx (
      .clk        (clk),
      .rst        (rst),
      .cs         (bus.cs),
      .dc         (bus.dc),
      .din        (bus.din),
      .byte_valid (byte_valid),
      .byte_dc    (byte_dc),
      .byte_data  (byte_data),
      .frame_err  (bus.frame_err)
   );

   dec_state_e  state_q, state_d;
   logic [2:0]  idx_q, idx_d;         // saturates at 4: extra params ignored
   logic [7:0]  hi_q, hi_d;           // high byte of a parameter word or pixel
   logic        lo_phase_q, lo_phase_d;
   coord_t      ptr_x_q, ptr_x_d, ptr_y_q, ptr_y_d;
   coord_t      win_xs_q, win_xs_d, win_xe_q, win_xe_d;
   coord_t      win_ys_q, win_ys_d, win_ye_q, win_ye_d;
   logic        cmd_valid_q, cmd_valid_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic        pix_valid_q, pix_valid_d;
   logic [15:0] pix_data_q, pix_data_d;
   coord_t      pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [15:0] word;

   assign word = {hi_q, byte_data};

   // State, window and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         idx_q       <= '0;
         hi_q        <= '0;
         lo_phase_q  <= 1'b0;
         ptr_x_q     <= '0;
         ptr_y_q     <= '0;
         win_xs_q    <= '0;
         win_xe_q    <= coord_t'(X_MAX);
         win_ys_q    <= '0;
         win_ye_q    <= coord_t'(Y_MAX);
         cmd_valid_q <= 1'b0;
         cmd_byte_q  <= '0;
         pix_valid_q <= 1'b0;
         pix_data_q  <= '0;
         pix_x_q     <= '0;
         pix_y_q     <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         hi_q        <= hi_d;
         lo_phase_q  <= lo_phase_d;
         ptr_x_q     <= ptr_x_d;
         ptr_y_q     <= ptr_y_d;
         win_xs_q    <= win_xs_d;
         win_xe_q    <= win_xe_d;
         win_ys_q    <= win_ys_d;
         win_ye_q    <= win_ye_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_byte_q  <= cmd_byte_d;
         pix_valid_q <= pix_valid_d;
         pix_data_q  <= pix_data_d;
         pix_x_q     <= pix_x_d;
         pix_y_q     <= pix_y_d;
      end
   end

   // Command decode, parameter collection and pixel pointer walk
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      hi_d        = hi_q;
      lo_phase_d  = lo_phase_q;
      ptr_x_d     = ptr_x_q;
      ptr_y_d     = ptr_y_q;
      win_xs_d    = win_xs_q;
      win_xe_d    = win_xe_q;
      win_ys_d    = win_ys_q;
      win_ye_d    = win_ye_q;
      cmd_valid_d = 1'b0;
      cmd_byte_d  = cmd_byte_q;
      pix_valid_d = 1'b0;
      pix_data_d  = pix_data_q;
      pix_x_d     = pix_x_q;
      pix_y_d     = pix_y_q;
      if (byte_valid && !byte_dc) begin
         cmd_valid_d = 1'b1;
         cmd_byte_d  = byte_data;
         idx_d       = '0;
         lo_phase_d  = 1'b0; // drops any pending high pixel byte
         case (byte_data)
            CMD_CASET: state_d = StCaset;
            CMD_PASET: state_d = StPaset;
            CMD_RAMWR: begin
               state_d = StRamwr;
               ptr_x_d = win_xs_q;
               ptr_y_d = win_ys_q;
            end
            default:   state_d = StSkip;
         endcase
      end else if (byte_valid) begin
         unique case (state_q)
            StCaset, StPaset: begin
               if (!idx_q[2]) begin
                  idx_d = idx_q + 3'd1;
                  case (idx_q[1:0])
                     2'd1: begin
                        if (state_q == StCaset) win_xs_d = word[COORD_W-1:0];
                        else                    win_ys_d = word[COORD_W-1:0];
                     end
                     2'd3: begin
                        if (state_q == StCaset) win_xe_d = word[COORD_W-1:0];
                        else                    win_ye_d = word[COORD_W-1:0];
                     end
                     default: hi_d = byte_data;
                  endcase
               end
            end
            StRamwr: begin
               if (!lo_phase_q) begin
                  hi_d       = byte_data;
                  lo_phase_d = 1'b1;
               end else begin
                  lo_phase_d  = 1'b0;
                  pix_valid_d = 1'b1;
                  pix_data_d  = word;
                  pix_x_d     = ptr_x_q;
                  pix_y_d     = ptr_y_q;
                  if (ptr_x_q == win_xe_q) begin
                     ptr_x_d = win_xs_q;
                     ptr_y_d = (ptr_y_q == win_ye_q) ? win_ys_q : ptr_y_q + coord_t'(1);
                  end else begin
                     ptr_x_d = ptr_x_q + coord_t'(1);
                  end
               end
            end
            StIdle, StSkip: ;
         endcase
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_byte  = cmd_byte_q;
   assign bus.pix_valid = pix_valid_q;
   assign bus.pix_data  = pix_data_q;
   assign bus.pix_x     = pix_x_q;
   assign bus.pix_y     = pix_y_q;
   assign bus.win_xs    = win_xs_q;
   assign bus.win_xe    = win_xe_q;
   assign bus.win_ys    = win_ys_q;
   assign bus.win_ye    = win_ye_q;

`ifdef ILI9341_DEC_PARAM_OUT_EN
   logic       param_hit;
   logic       param_valid_q;
   logic [7:0] param_byte_q;

   assign param_hit = byte_valid && byte_dc &&
                      (state_q == StCaset || state_q == StPaset || state_q == StSkip);

   // Report parameter bytes of non-RAMWR commands
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         param_valid_q <= 1'b0;
         param_byte_q  <= '0;
      end else begin
         param_valid_q <= param_hit;
         if (param_hit) param_byte_q <= byte_data;
      end
   end

   assign bus.param_valid = param_valid_q;
   assign bus.param_byte  = param_byte_q;
`else
   assign bus.param_valid = 1'b0;
   assign bus.param_byte  = '0;
`endif
endmodule

// File: doc/ili9341_spi_decoder.md
# ili9341_spi_decoder

Receive-side decoder for the ILI9341 4-wire serial link (cs, dc, din clocked by clk) driven by the team's display writers. It deserialises bytes, interprets column-address set (0x2A), page-address set (0x2B) and memory-write (0x2C), and emits addressed 16-bit RGB565 pixel strobes. It serves as a framebuffer-mirror front end and as the bench-side checker for the writer blocks.

## Interface
- COORD_W, 9: width of stored window bounds and pixel coordinates; the low COORD_W bits of each 16-bit parameter are kept.
- X_MAX, 239: reset value of the column end bound.
- Y_MAX, 319: reset value of the page end bound.
- clk  in  1  system clock and serial bit clock; all inputs sampled on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cs  in  1  chip select, active low; a high level aborts any partial byte.
- dc  in  1  0 = command byte, 1 = parameter/data byte; sampled with the eighth bit.
- din  in  1  serial data, MSB first.
- cmd_valid  out  1  one-cycle pulse on every completed command byte.
- cmd_byte  out  8  last command byte; held.
- param_valid  out  1  one-cycle pulse per parameter byte of a non-RAMWR command (see Configuration).
- param_byte  out  8  last parameter byte; held.
- pix_valid  out  1  one-cycle pulse per completed pixel.
- pix_data  out  16  RGB565 pixel; held.
- pix_x, pix_y  out  COORD_W  coordinates of the pixel on pix_data.
- win_xs, win_xe, win_ys, win_ye  out  COORD_W  current window bounds.
- frame_err  out  1  one-cycle pulse when cs rises with 1–7 bits collected.

## Operation
- Byte receiver: 8-bit shift register plus 3-bit bit counter; advances only on edges with cs=0. The eighth bit completes a byte, tagged with dc sampled on that edge. cs=1 clears the counter; if counter was nonzero, frame_err pulses.
- Word framing is ignored: 16- and 32-bit writer words decode as consecutive bytes; cs deassertion between words is legal.
- Decoder FSM states: IDLE, CASET (param index 0–3), PASET (param index 0–3), RAMWR (byte phase hi/lo), SKIP.
- Any command byte, in any state: pulse cmd_valid, then 0x2A→CASET idx 0; 0x2B→PASET idx 0; 0x2C→RAMWR, pointer := (win_xs, win_ys), phase hi; otherwise→SKIP. A pending high pixel byte is discarded.
- CASET/PASET: bytes 0/1 form start (hi, lo); bytes 2/3 form end. Start bound updates after byte 1 and end bound after byte 3. Bytes beyond 3 are ignored. Start > end is stored unchecked.
- RAMWR: hi byte latched; lo byte completes pixel → pix_valid, pix_data={hi,lo}, pix_x/pix_y=pointer. Pointer then advances: x==win_xe → x:=win_xs, y:=y+1 (y==win_ye → y:=win_ys); else x+1. Arithmetic is COORD_W-bit modulo.
- Data bytes in IDLE are ignored.
- Reset values: all pulses 0, held bytes 0, pix_x/pix_y 0, win_xs=0, win_xe=X_MAX, win_ys=0, win_ye=Y_MAX, FSM IDLE, bit counter 0.

## Timing
- Writer launches on falling edge; decoder samples on rising edge.
- Zero added latency: all strobes and held outputs update on the rising edge that samples the eighth bit and stay asserted for exactly one cycle.
- Back-to-back bytes (no cs gap) are supported at one bit per cycle.
- Reset mid-byte or mid-command discards everything, with no frame_err.

## Configuration
- ILI9341_DEC_PARAM_OUT_EN defined: param_valid/param_byte report every parameter byte of CASET, PASET and SKIP commands.
- Not defined: param_valid is tied 0 and param_byte is tied 0; collection logic for those outputs is removed.

## Structure
- Shared package ili9341_pkg: opcode constants CMD_CASET=8'h2A, CMD_PASET=8'h2B, CMD_RAMWR=8'h2C, and the decoder state enum; writers reuse the opcodes.
- Sub-module ili9341_spi_byte_rx: shift register, bit counter, cs abort, frame_err, and byte_valid/byte_dc/byte_data outputs. The top module holds the FSM and pointer.

## Test plan
- Send 0x2A then 00 16 00 D8 → cmd_valid with 0x2A; win_xs=22, win_xe=216. Send 0x2B then 00 3E 01 00 → win_ys=62, win_ye=256.
- After the window above, send 0x2C then F8 00 → pix_valid once, pix_data=0xF800, pix_x=22, pix_y=62.
- Stream 195 pixels → the 195th at (216,62) and the 196th at (22,63). Fill to (216,256) → the next pixel is at (22,62).
- During RAMWR, send hi byte 0x07 then command 0x2C then E0 1F → single pixel 0xE01F at (win_xs,win_ys); 0x07 is dropped.
- Raise cs after 5 bits → frame_err one cycle, no strobe. The next full byte decodes correctly.
- Assert rst mid-CASET after 2 params → bounds return to 0/239/0/319 and FSM returns to IDLE. With the macro defined, send 0x36 then 0x48 → param_valid with 0x48. Without the macro, param_valid stays 0.
